// File: rtl/pipe_issue_sched.sv
// ID-stage issue scheduler: per-register pending-write scoreboard, RAW stalls, EX redirect flush
// and syscall drain/hand-off. Optional stall counter under `define PIPE_SCHED_PERF_EN.
module pipe_issue_sched #(
    parameter int PEND_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        id_valid,
    input  logic [4:0]  id_req_a,
    input  logic        id_ra,
    input  logic [4:0]  id_req_b,
    input  logic        id_rb,
    input  logic        id_we,
    input  logic [4:0]  id_req_w,
    input  logic        id_syscall,
    input  logic        ex_redirect,
    input  logic        wb_we,
    input  logic [4:0]  wb_req_w,
    input  logic        sys_done,
    output logic        issue,
    output logic        stall_if,
    output logic        stall_id,
    output logic        flush_id,
    output logic        sys_go,
    output logic        sb_err,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, DRAIN, SYS} state_t;

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_t            state;
    state_t            state_nxt;
    logic              go_nxt;
    logic [PEND_W-1:0] pend     [32];
    logic [PEND_W-1:0] pend_nxt [32];
    logic              err_nxt;
    logic              haz;
    logic              drained;
    logic              sb_inc;
    logic              sb_dec;

    // Entry 0 stays zero, so r0 can never raise a hazard.
    assign haz = (id_ra && id_req_a != 5'd0 && pend[id_req_a] != '0)
               | (id_rb && id_req_b != 5'd0 && pend[id_req_b] != '0)
               | (id_we && id_req_w != 5'd0 && pend[id_req_w] == PEND_MAX);

    // Only decrements happen while draining, so this cycle's WB alone can finish the drain.
    always_comb begin
        drained = 1'b1;
        for (int r = 1; r < 32; r++) begin
            if (pend[r] != '0 &&
                !(pend[r] == PEND_W'(1) && sb_dec && wb_req_w == 5'(r)))
                drained = 1'b0;
        end
    end

    always_comb begin
        issue     = 1'b0;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        flush_id  = 1'b0;
        go_nxt    = 1'b0;
        state_nxt = state;
        if (ex_redirect) begin
            flush_id  = 1'b1;
            state_nxt = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (id_valid) begin
                        if (id_syscall) begin
                            stall_if  = 1'b1;
                            stall_id  = 1'b1;
                            state_nxt = DRAIN;
                        end else begin
                            issue    = !haz;
                            stall_if = haz;
                            stall_id = haz;
                        end
                    end
                end
                DRAIN: begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    if (drained) begin
                        go_nxt    = 1'b1;
                        state_nxt = SYS;
                    end
                end
                SYS: begin
                    if (sys_done) begin
                        issue     = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // The syscall retiring from SYS never writes the RF, so only RUN issues allocate.
    assign sb_inc = issue && id_we && state == RUN && id_req_w != 5'd0;
    assign sb_dec = wb_we && wb_req_w != 5'd0;

    always_comb begin
        err_nxt     = 1'b0;
        pend_nxt[0] = '0;
        for (int r = 1; r < 32; r++) begin
            pend_nxt[r] = pend[r];
            if (sb_inc && id_req_w == 5'(r) && !(sb_dec && wb_req_w == 5'(r))) begin
                if (pend[r] == PEND_MAX) err_nxt = 1'b1;
                else                     pend_nxt[r] = pend[r] + PEND_W'(1);
            end else if (sb_dec && wb_req_w == 5'(r) && !(sb_inc && id_req_w == 5'(r))) begin
                if (pend[r] == '0) err_nxt = 1'b1;
                else               pend_nxt[r] = pend[r] - PEND_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            sys_go <= 1'b0;
            sb_err <= 1'b0;
            for (int r = 0; r < 32; r++) pend[r] <= '0;
        end else if (en) begin
            state  <= state_nxt;
            sys_go <= go_nxt;
            sb_err <= sb_err | err_nxt;
            for (int r = 0; r < 32; r++) pend[r] <= pend_nxt[r];
        end
    end

`ifdef PIPE_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= 32'd0;
        else if (en && stall_id)
            stall_cnt <= stall_cnt + 32'd1;
    end
`else
    assign stall_cnt = 32'd0;
`endif

endmodule
